keypress_decoder: RTL and testbench

- Converts the raw PS/2 scan-code byte stream from the keyboard receiver into clean keypress events, each a 5-bit letter index (A=0 … Z=25).
- Sits between the PS/2 receiver and the rotor/reflector chain, which it feeds through a ready/valid interface.
- Consumes make/break prefixes, suppresses typematic auto-repeat, and buffers events in a small FIFO, so each physical key press produces exactly one encryption step.

---
 rtl/enigma_pkg.sv | 44 ++++
 rtl/letter_fifo.sv | 57 +++++
 rtl/keypress_decoder.sv | 115 +++++++++++
 tb/tb_keypress_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared scan-code constants, letter make-code table and parser states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package enigma_pkg;

  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam int         NUM_LETTERS = 26;
  localparam int         LETTER_W    = 5;

  // Make codes for A..Z; the array position is the letter index.
  localparam logic [7:0] MAKE_TABLE [NUM_LETTERS] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
  };

  typedef enum logic [1:0] {
    IDLE,
    BREAK,
    EXT,
    EXT_BREAK
  } parse_state_t;

  function automatic logic is_letter(input logic [7:0] sc);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (MAKE_TABLE[i] == sc) hit = 1'b1;
    end
    return hit;
  endfunction

  // Returns 0 for non-letter codes; callers qualify with is_letter.
  function automatic logic [LETTER_W-1:0] scan_to_index(input logic [7:0] sc);
    logic [LETTER_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (MAKE_TABLE[i] == sc) idx = LETTER_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/letter_fifo.sv
// letter_fifo: small synchronous FIFO holding letter events.
// Latency: a push into an empty FIFO is visible at the head the next cycle.
// Backpressure: push when full is ignored unless a pop happens the same cycle; pop when empty is ignored.
module letter_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign do_push  = push && (!full || do_pop);
  // Head reads as zero while empty so the output is clean out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset since occupancy gates the head.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/keypress_decoder.sv
// keypress_decoder: PS/2 scan-code bytes -> exactly one letter event per physical key press.
// Latency: make byte strobed in cycle N is at the FIFO head in cycle N+1 when the FIFO was empty.
// Backpressure: ready/valid output through a FIFO; when full and not draining, new events drop and overflow sticks.
module keypress_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int LETTER_W   = 5
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        code_valid,
  input  logic [7:0]                  code,
  output logic                        letter_valid,
  input  logic                        letter_ready,
  output logic [LETTER_W-1:0]         letter,
  output logic                        held,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  import enigma_pkg::*;

  parse_state_t        state;
  parse_state_t        state_next;
  logic [7:0]          held_code;
  logic                push_req;
  logic                set_held;
  logic                clr_held;
  logic                pop;
  logic                full;
  logic                empty;
  logic [LETTER_W-1:0] make_idx;

  assign make_idx     = scan_to_index(code);
  assign letter_valid = !empty;
  assign pop          = letter_valid && letter_ready;

  // Parser state register; reset drops any half-received prefix.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Prefix tracking: the parser only moves on strobed bytes.
  always_comb begin
    state_next = state;
    if (code_valid) begin
      case (state)
        IDLE: begin
          if (code == SC_BREAK)    state_next = BREAK;
          else if (code == SC_EXT) state_next = EXT;
        end
        BREAK:     state_next = IDLE;
        EXT:       state_next = (code == SC_BREAK) ? EXT_BREAK : IDLE;
        EXT_BREAK: state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  // Event generation: push fresh letter makes, release held on a matching break.
  always_comb begin
    push_req = 1'b0;
    set_held = 1'b0;
    clr_held = 1'b0;
    if (code_valid) begin
      case (state)
        IDLE: begin
          if (is_letter(code) && !(held && code == held_code)) begin
            push_req = 1'b1;
            set_held = 1'b1;
          end
        end
        BREAK: begin
          if (held && code == held_code) clr_held = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Held-key tracking; updates even when the FIFO drops the event so repeats stay suppressed.
  always_ff @(posedge clock) begin
    if (reset) begin
      held      <= 1'b0;
      held_code <= '0;
    end else if (set_held) begin
      held      <= 1'b1;
      held_code <= code;
    end else if (clr_held) begin
      held      <= 1'b0;
    end
  end

  // Sticky drop flag: a push lost to a full FIFO that is not draining this cycle.
  always_ff @(posedge clock) begin
    if (reset)                          overflow <= 1'b0;
    else if (push_req && full && !pop)  overflow <= 1'b1;
  end

  letter_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LETTER_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_req),
    .push_data (make_idx),
    .pop       (pop),
    .pop_data  (letter),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

endmodule

// File: tb/tb_keypress_decoder.sv
// tb_keypress_decoder: directed scenarios plus randomized traffic against a queue-based model.
// Latency: n/a.
// Backpressure: letter_ready driven per cycle by the stimulus.
module tb_keypress_decoder;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       code_valid;
  logic [7:0] code;
  logic       letter_valid;
  logic       letter_ready;
  logic [4:0] letter;
  logic       held;
  logic       overflow;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;

  always #10 clock = ~clock;

  keypress_decoder #(
    .FIFO_DEPTH (DEPTH),
    .LETTER_W   (5)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .code_valid   (code_valid),
    .code         (code),
    .letter_valid (letter_valid),
    .letter_ready (letter_ready),
    .letter       (letter),
    .held         (held),
    .overflow     (overflow),
    .count        (count)
  );

  // Reference model: letters as a lookup list, prefixes as a byte queue, FIFO as a queue.
  logic [7:0] keymap [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
  };
  int         m_q[$];
  logic [7:0] m_prefix[$];
  bit         m_held;
  logic [7:0] m_hcode;
  bit         m_ovf;
  int         got[$];
  int         exp_pop[$];
  int         valid_seen;

  function automatic int idx_of(input logic [7:0] b);
    int r;
    r = -1;
    for (int i = 0; i < 26; i++) if (keymap[i] == b) r = i;
    return r;
  endfunction

  // Returns the letter index to enqueue, or -1.
  function automatic int model_byte(input logic [7:0] b);
    int r;
    r = -1;
    if (m_prefix.size() == 0) begin
      if (b == 8'hF0 || b == 8'hE0) m_prefix.push_back(b);
      else if (idx_of(b) >= 0 && !(m_held && m_hcode == b)) begin
        r = idx_of(b);
        m_held = 1'b1;
        m_hcode = b;
      end
    end else if (m_prefix.size() == 1 && m_prefix[0] == 8'hF0) begin
      if (m_held && m_hcode == b) m_held = 1'b0;
      m_prefix.delete();
    end else if (m_prefix.size() == 1) begin
      if (b == 8'hF0) m_prefix.push_back(b);
      else m_prefix.delete();
    end else begin
      m_prefix.delete();
    end
    return r;
  endfunction

  // One clock: drive inputs, record what the DUT offers, advance the model at the edge.
  task automatic cycle(input bit cv, input logic [7:0] b, input bit rdy);
    bit popped;
    int p;
    code_valid   = cv;
    code         = b;
    letter_ready = rdy;
    popped = rdy && (m_q.size() > 0);
    if (letter_valid === 1'b1) valid_seen++;
    if (letter_valid === 1'b1 && rdy) got.push_back(int'(letter));
    @(posedge clock);
    if (popped) exp_pop.push_back(m_q.pop_front());
    if (cv) begin
      p = model_byte(b);
      if (p >= 0) begin
        if (m_q.size() < DEPTH) m_q.push_back(p);
        else m_ovf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    cycle(1'b1, b, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    code_valid   = 1'b0;
    code         = 8'h00;
    letter_ready = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_q.delete();
    m_prefix.delete();
    m_held = 1'b0;
    m_hcode = 8'h00;
    m_ovf = 1'b0;
    got.delete();
    exp_pop.delete();
    valid_seen = 0;
  endtask

  task automatic fill_four();
    logic [7:0] seq [10] = '{8'h1C, 8'hF0, 8'h1C, 8'h32, 8'hF0, 8'h32, 8'h21, 8'hF0, 8'h21, 8'h23};
    for (int i = 0; i < 10; i++) send(seq[i], 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (letter_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b exp=0", letter_valid); end
    tests++; if (letter !== 5'd0) begin fails++; $display("FAIL reset_letter got=%0d exp=0", letter); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
    tests++; if (held !== 1'b0) begin fails++; $display("FAIL reset_held got=%0b exp=0", held); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
  endtask

  task automatic test_latency();
    do_reset();
    send(8'h1C, 1'b1);
    tests++; if (letter_valid !== 1'b1) begin fails++; $display("FAIL lat_valid got=%0b exp=1", letter_valid); end
    tests++; if (letter !== 5'd0) begin fails++; $display("FAIL lat_letter got=%0d exp=0", letter); end
    tests++; if (held !== 1'b1) begin fails++; $display("FAIL lat_held got=%0b exp=1", held); end
    idle(1, 1'b1);
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL lat_count got=%0d exp=0", count); end
  endtask

  task automatic test_autorepeat();
    logic [7:0] seq [5] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    do_reset();
    for (int i = 0; i < 5; i++) send(seq[i], 1'b1);
    tests++; if (held !== 1'b0) begin fails++; $display("FAIL rep_held_after_break got=%0b exp=0", held); end
    send(8'h1C, 1'b1);
    tests++; if (held !== 1'b1) begin fails++; $display("FAIL rep_held_end got=%0b exp=1", held); end
    idle(2, 1'b1);
    tests++; if (got.size() != 2) begin fails++; $display("FAIL rep_events got=%0d exp=2", got.size()); end
    else begin
      tests++; if (got[0] != 0 || got[1] != 0) begin fails++; $display("FAIL rep_letters got=%0d,%0d exp=0,0", got[0], got[1]); end
    end
  endtask

  task automatic test_prefixes();
    logic [7:0] seq [7] = '{8'hF0, 8'h32, 8'hE0, 8'h1C, 8'hE0, 8'hF0, 8'h1C};
    do_reset();
    for (int i = 0; i < 7; i++) send(seq[i], 1'b1);
    idle(2, 1'b1);
    tests++; if (valid_seen != 0) begin fails++; $display("FAIL pre_no_events got=%0d exp=0", valid_seen); end
    tests++; if (held !== 1'b0) begin fails++; $display("FAIL pre_held got=%0b exp=0", held); end
    send(8'h21, 1'b0);
    tests++; if (letter_valid !== 1'b1 || letter !== 5'd2) begin fails++; $display("FAIL pre_back_to_idle got=%0b/%0d exp=1/2", letter_valid, letter); end
  endtask

  task automatic test_overflow();
    do_reset();
    fill_four();
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL ovf_full_count got=%0d exp=4", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_not_yet got=%0b exp=0", overflow); end
    send(8'h24, 1'b0);
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL ovf_count got=%0d exp=4", count); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    idle(6, 1'b1);
    tests++; if (got.size() != 4 || got[0] != 0 || got[1] != 1 || got[2] != 2 || got[3] != 3) begin
      fails++; $display("FAIL ovf_drain got=%p exp=0,1,2,3", got);
    end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL ovf_drained_count got=%0d exp=0", count); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    fill_four();
    send(8'h2B, 1'b1);
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL fpp_count got=%0d exp=4", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fpp_overflow got=%0b exp=0", overflow); end
    idle(6, 1'b1);
    tests++; if (got.size() != 5 || got[0] != 0 || got[1] != 1 || got[2] != 2 || got[3] != 3 || got[4] != 5) begin
      fails++; $display("FAIL fpp_order got=%p exp=0,1,2,3,5", got);
    end
  endtask

  task automatic test_reset_midseq();
    do_reset();
    send(8'hF0, 1'b1);
    do_reset();
    send(8'h1C, 1'b0);
    tests++; if (letter_valid !== 1'b1 || letter !== 5'd0) begin fails++; $display("FAIL mid_reset got=%0b/%0d exp=1/0", letter_valid, letter); end
    tests++; if (held !== 1'b1) begin fails++; $display("FAIL mid_reset_held got=%0b exp=1", held); end
  endtask

  task automatic test_random();
    logic [7:0] pool [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'hF0, 8'hE0, 8'hE1, 8'h00};
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), pool[$urandom_range(0, 8)], 1'($urandom_range(0, 1)));
      tests++;
      if (letter_valid !== (m_q.size() > 0) || count !== 3'(m_q.size()) || held !== m_held || overflow !== m_ovf ||
          (m_q.size() > 0 && letter !== 5'(m_q[0]))) begin
        fails++;
        if (bad < 10) $display("FAIL rand_state cyc=%0d got v=%0b l=%0d c=%0d h=%0b o=%0b exp c=%0d h=%0b o=%0b",
                               i, letter_valid, letter, count, held, overflow, m_q.size(), m_held, m_ovf);
        bad++;
      end
    end
    tests++; if (got != exp_pop) begin fails++; $display("FAIL rand_stream got_n=%0d exp_n=%0d", got.size(), exp_pop.size()); end
  endtask

  initial begin
    reset = 1'b1;
    code_valid = 1'b0;
    code = 8'h00;
    letter_ready = 1'b0;
    #1;
    test_reset();
    test_latency();
    test_autorepeat();
    test_prefixes();
    test_overflow();
    test_full_push_pop();
    test_reset_midseq();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
